sad_ex6_unit: RTL and testbench
===============================

SAD_EX6_UNIT -- requirements
Module: sad_ex6_unit

Interface
REQ-001 Parameter NUM_PIX, default 16, number of window/template pixel pairs per SAD op.
REQ-002 Parameter PIX_W, default 32, width of each pixel word.
REQ-003 Clk  input  1  sole clock; all state changes on posedge Clk.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 sad_valid_EX6  input  1  EX6 holds a valid SAD custom instruction.
REQ-006 first_EX6  input  1  op is the first candidate of a new search; best-match state restarts.
REQ-007 ReadData_EX6  input  NUM_PIX*PIX_W  packed window pixels; pixel i at bits [i*PIX_W +: PIX_W].
REQ-008 tReadData_EX6  input  NUM_PIX*PIX_W  packed template pixels, same packing.
REQ-009 outx_EX6, outy_EX6  input  32 each  candidate coordinates carried with the op.
REQ-010 Stall  input  1  freeze the whole unit.
REQ-011 Flush  input  1  kill all in-flight ops.
REQ-012 sad_result  output  32  SAD of the op leaving stage C.
REQ-013 sad_result_valid  output  1  sad_result is valid this cycle.
REQ-014 best_sad, best_x, best_y  output  32 each  current minimum SAD and its coordinates.
REQ-015 best_valid  output  1  at least one candidate has been scored since the last first_EX6 or reset.
REQ-016 busy  output  1  OR of the stage A/B/C valid bits.

Function
REQ-017 Stage A: when sad_valid_EX6 is 1, latch |ReadData_i - tReadData_i| (unsigned, PIX_W bits) for every i, plus outx/outy/first and valid.
REQ-018 Stage B: latch 4 partial sums, each of 4 stage-A differences, PIX_W+2 bits wide, no overflow.
REQ-019 Stage C: latch the total of the 4 partials, PIX_W+4 bits wide; sad_result is that total saturated to 32'hFFFFFFFF.
REQ-020 Latency: sad_result_valid rises exactly 3 cycles after the input cycle, with no stall in between; 1 op/cycle throughput.
REQ-021 Best update happens on the cycle after stage C holds a valid op (latency 4 from the input cycle).
REQ-022 Update if first=1 for that op: best_sad, best_x, best_y are loaded unconditionally and best_valid is set to 1.
REQ-023 Otherwise, update only if sad_result < best_sad (strict); on a tie the earlier candidate is kept.
REQ-024 Stall=1: every pipeline register, valid bit and best register holds; outputs stay constant.
REQ-025 Flush=1: valid bits of stages A, B and C are cleared on the next edge and an input valid that cycle is dropped; best registers are untouched.
REQ-026 Flush and Stall in the same cycle: Flush wins.
REQ-027 first_EX6 arriving while older ops are in flight: the older ops still update best in order, before the first op reloads it.
REQ-028 Pipeline data registers may hold stale values when their valid bit is 0; only valid-qualified outputs are checked.

Reset
REQ-029 Reset asserted clears all valid bits, sad_result, best_x, best_y and best_valid to 0, and sets best_sad to 32'hFFFFFFFF, immediately, without waiting for Clk.
REQ-030 Reset mid-operation discards all in-flight ops; no sad_result_valid appears for them after Reset deasserts.

Structure
REQ-031 A shared package sad_pkg holds NUM_PIX, PIX_W, SUM_W (=PIX_W+4), SAD_MAX (32'hFFFFFFFF) and the packed pixel-bus type.
REQ-032 One sub-module sad_tree4 (combinational 4-input absolute-difference sum) is instantiated 4 times; stage registers stay in sad_ex6_unit.

Verification
REQ-033 Cover single op: all window pixels 10, all template pixels 7, first=1, x=3, y=5 -> sad_result=48 with valid at cycle+3; at cycle+4, best_sad=48, best=(3,5), best_valid=1.
REQ-034 Cover back-to-back ops: SADs of 48, then 20 (x=4,y=5), then 20 (x=6,y=6) -> final best_sad=20, best=(4,5) (tie keeps the earlier candidate).
REQ-035 Cover saturation: all window pixels 32'hFFFFFFFF, template pixels 0 -> sad_result=32'hFFFFFFFF.
REQ-036 Cover Stall: Stall=1 for 2 cycles while an op sits in stage B -> sad_result_valid is delayed exactly 2 cycles and the value is unchanged.
REQ-037 Cover Flush plus first: Flush with 3 ops in flight -> no sad_result_valid, best unchanged; a later first=1 op with SAD 100 -> best_sad=100 even though it is larger than the previous best.
REQ-038 Cover Reset while busy=1 -> busy=0 and best_sad=32'hFFFFFFFF immediately, and no result is emitted afterwards.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared definitions for the EX6 sum-of-absolute-differences unit.
//   NUM_PIX  : pixel pairs per SAD op
//   PIX_W    : pixel word width
//   SUM_W    : width of the full (unsaturated) SAD total
//   SAD_MAX  : saturated SAD value, also the "no best yet" marker
//   pix_bus_t: packed pixel bus, pixel i at bits [i*PIX_W +: PIX_W]
package sad_pkg;
  localparam int NUM_PIX = 16;
  localparam int PIX_W   = 32;
  localparam int SUM_W   = PIX_W + 4;

  localparam logic [31:0] SAD_MAX = 32'hFFFF_FFFF;

  typedef logic [NUM_PIX*PIX_W-1:0] pix_bus_t;
endpackage

// File: rtl/sad_tree4.sv
// Combinational sum of four absolute differences.
//   diffs : four packed PIX_W-bit absolute differences
//   sum   : their total, PIX_W+2 bits so it can never overflow
module sad_tree4 #(
  parameter int PIX_W = sad_pkg::PIX_W
) (
  input  logic [4*PIX_W-1:0] diffs,
  output logic [PIX_W+1:0]   sum
);
  localparam int SW = PIX_W + 2;

  assign sum = SW'(diffs[0*PIX_W +: PIX_W]) + SW'(diffs[1*PIX_W +: PIX_W])
             + SW'(diffs[2*PIX_W +: PIX_W]) + SW'(diffs[3*PIX_W +: PIX_W]);
endmodule

// File: rtl/sad_ex6_unit.sv
// Three-stage SAD pipeline for the EX6 custom instruction with a running
// best-match (minimum SAD) tracker.
//   Clk, Reset                     : clock, async active-high reset
//   sad_valid_EX6, first_EX6       : op valid, op starts a new search
//   ReadData_EX6, tReadData_EX6    : packed window / template pixels
//   outx_EX6, outy_EX6             : candidate coordinates
//   Stall, Flush                   : freeze unit / kill in-flight ops
//   sad_result, sad_result_valid   : saturated SAD leaving stage C
//   best_sad, best_x, best_y       : current minimum and its position
//   best_valid                     : a candidate has been scored
//   busy                           : any pipeline stage occupied
// The reduction is built as four sad_tree4 instances, so NUM_PIX must be 16
// and PIX_W must be at least 28 for the 32-bit saturation slice.
module sad_ex6_unit #(
  parameter int NUM_PIX = sad_pkg::NUM_PIX,
  parameter int PIX_W   = sad_pkg::PIX_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     sad_valid_EX6,
  input  logic                     first_EX6,
  input  logic [NUM_PIX*PIX_W-1:0] ReadData_EX6,
  input  logic [NUM_PIX*PIX_W-1:0] tReadData_EX6,
  input  logic [31:0]              outx_EX6,
  input  logic [31:0]              outy_EX6,
  input  logic                     Stall,
  input  logic                     Flush,
  output logic [31:0]              sad_result,
  output logic                     sad_result_valid,
  output logic [31:0]              best_sad,
  output logic [31:0]              best_x,
  output logic [31:0]              best_y,
  output logic                     best_valid,
  output logic                     busy
);
  import sad_pkg::*;

  localparam int PART_W = PIX_W + 2;
  localparam int TOT_W  = PIX_W + 4;

  logic [NUM_PIX*PIX_W-1:0] diff_d, a_diff;
  logic [PART_W-1:0]        part_d [4];
  logic [PART_W-1:0]        b_part [4];
  logic [TOT_W-1:0]         total_d, c_total;
  logic [31:0]              a_x, a_y, b_x, b_y, c_x, c_y;
  logic                     a_first, b_first, c_first;
  logic                     a_vld, b_vld, c_vld;
  logic                     best_upd;

  for (genvar g = 0; g < NUM_PIX; g++) begin : g_absdiff
    assign diff_d[g*PIX_W +: PIX_W] =
      (ReadData_EX6[g*PIX_W +: PIX_W] > tReadData_EX6[g*PIX_W +: PIX_W])
        ? ReadData_EX6[g*PIX_W +: PIX_W] - tReadData_EX6[g*PIX_W +: PIX_W]
        : tReadData_EX6[g*PIX_W +: PIX_W] - ReadData_EX6[g*PIX_W +: PIX_W];
  end

  for (genvar t = 0; t < 4; t++) begin : g_tree
    sad_tree4 #(.PIX_W(PIX_W)) u_tree (
      .diffs (a_diff[t*4*PIX_W +: 4*PIX_W]),
      .sum   (part_d[t])
    );
  end

  assign total_d = TOT_W'(b_part[0]) + TOT_W'(b_part[1])
                 + TOT_W'(b_part[2]) + TOT_W'(b_part[3]);

  assign sad_result       = (c_total > TOT_W'(SAD_MAX)) ? SAD_MAX : c_total[31:0];
  assign sad_result_valid = c_vld;
  assign busy             = a_vld | b_vld | c_vld;

  // A first op reloads the tracker regardless of value; otherwise strictly
  // smaller wins so ties keep the earlier candidate.
  assign best_upd = c_vld && !Stall && !Flush && (c_first || (sad_result < best_sad));

  // Data registers carry no reset: they are only observed through valid bits.
  always_ff @(posedge Clk) begin
    if (!Stall) begin
      a_diff  <= diff_d;
      a_x     <= outx_EX6;
      a_y     <= outy_EX6;
      a_first <= first_EX6;
      b_part  <= part_d;
      b_x     <= a_x;
      b_y     <= a_y;
      b_first <= a_first;
      c_x     <= b_x;
      c_y     <= b_y;
      c_first <= b_first;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_vld      <= 1'b0;
      b_vld      <= 1'b0;
      c_vld      <= 1'b0;
      c_total    <= '0;
      best_sad   <= SAD_MAX;
      best_x     <= '0;
      best_y     <= '0;
      best_valid <= 1'b0;
    end else begin
      // Flush overrides Stall and also swallows this cycle's input.
      if (Flush) begin
        a_vld <= 1'b0;
        b_vld <= 1'b0;
        c_vld <= 1'b0;
      end else if (!Stall) begin
        a_vld <= sad_valid_EX6;
        b_vld <= a_vld;
        c_vld <= b_vld;
      end
      if (!Stall) begin
        c_total <= total_d;
      end
      if (best_upd) begin
        best_sad   <= sad_result;
        best_x     <= c_x;
        best_y     <= c_y;
        best_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sad_ex6_unit.sv
module tb_sad_ex6_unit;
  import sad_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        sad_valid_EX6 = 1'b0;
  logic        first_EX6 = 1'b0;
  pix_bus_t    ReadData_EX6 = '0;
  pix_bus_t    tReadData_EX6 = '0;
  logic [31:0] outx_EX6 = '0;
  logic [31:0] outy_EX6 = '0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [31:0] sad_result, best_sad, best_x, best_y;
  logic        sad_result_valid, best_valid, busy;

  sad_ex6_unit dut (
    .Clk(Clk), .Reset(Reset), .sad_valid_EX6(sad_valid_EX6), .first_EX6(first_EX6),
    .ReadData_EX6(ReadData_EX6), .tReadData_EX6(tReadData_EX6),
    .outx_EX6(outx_EX6), .outy_EX6(outy_EX6), .Stall(Stall), .Flush(Flush),
    .sad_result(sad_result), .sad_result_valid(sad_result_valid),
    .best_sad(best_sad), .best_x(best_x), .best_y(best_y),
    .best_valid(best_valid), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: each in-flight op is a record aged in unstalled cycles.
  // Age 3 means it is the result on the output; the next advancing edge
  // scores it against the best and retires it.
  typedef struct {
    logic [31:0] sad;
    logic [31:0] x;
    logic [31:0] y;
    bit          first;
    int          age;
  } op_t;

  op_t         q[$];
  logic [31:0] m_best_sad, m_best_x, m_best_y;
  bit          m_best_valid;

  function automatic logic [31:0] ref_sad(input pix_bus_t w, input pix_bus_t t);
    longint unsigned s = 0;
    longint unsigned a, b;
    for (int i = 0; i < NUM_PIX; i++) begin
      a = longint'(w[i*PIX_W +: PIX_W]);
      b = longint'(t[i*PIX_W +: PIX_W]);
      s += (a > b) ? a - b : b - a;
    end
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_best_sad   = 32'hFFFF_FFFF;
    m_best_x     = 0;
    m_best_y     = 0;
    m_best_valid = 1'b0;
  endtask

  task automatic model_step();
    op_t n;
    if (Reset) begin
      model_reset();
    end else if (Flush) begin
      q.delete();
    end else if (!Stall) begin
      if (q.size() > 0 && q[0].age == 3) begin
        if (q[0].first || q[0].sad < m_best_sad) begin
          m_best_sad   = q[0].sad;
          m_best_x     = q[0].x;
          m_best_y     = q[0].y;
          m_best_valid = 1'b1;
        end
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].age++;
      if (sad_valid_EX6) begin
        n.sad   = ref_sad(ReadData_EX6, tReadData_EX6);
        n.x     = outx_EX6;
        n.y     = outy_EX6;
        n.first = first_EX6;
        n.age   = 1;
        q.push_back(n);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic drive_uniform(input logic [31:0] wv, input logic [31:0] tv,
                               input bit fst, input logic [31:0] x, input logic [31:0] y);
    for (int i = 0; i < NUM_PIX; i++) begin
      ReadData_EX6[i*PIX_W +: PIX_W]  = wv;
      tReadData_EX6[i*PIX_W +: PIX_W] = tv;
    end
    sad_valid_EX6 = 1'b1;
    first_EX6     = fst;
    outx_EX6      = x;
    outy_EX6      = y;
  endtask

  task automatic drive_single(input logic [31:0] wv, input logic [31:0] tv,
                              input bit fst, input logic [31:0] x, input logic [31:0] y);
    ReadData_EX6  = '0;
    tReadData_EX6 = '0;
    ReadData_EX6[PIX_W-1:0]  = wv;
    tReadData_EX6[PIX_W-1:0] = tv;
    sad_valid_EX6 = 1'b1;
    first_EX6     = fst;
    outx_EX6      = x;
    outy_EX6      = y;
  endtask

  task automatic idle();
    sad_valid_EX6 = 1'b0;
    first_EX6     = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        chk("result_valid", 32'(sad_result_valid), 32'(q.size() > 0 && q[0].age == 3));
        if (q.size() > 0 && q[0].age == 3) chk("sad_result", sad_result, q[0].sad);
        chk("best_sad", best_sad, m_best_sad);
        chk("best_x", best_x, m_best_x);
        chk("best_y", best_y, m_best_y);
        chk("best_valid", 32'(best_valid), 32'(m_best_valid));
        chk("busy", 32'(busy), 32'(q.size() > 0));
      end
    end
  end

  initial begin
    #1 Reset = 1'b1;
    model_reset();
    #1;
    chk("rst_best_sad", best_sad, 32'hFFFF_FFFF);
    chk("rst_best_valid", 32'(best_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", sad_result, 32'd0);
    tick();
    tick();
    Reset = 1'b0;
    chk_en = 1'b1;

    // Single op: 16 * |10-7| = 48.
    drive_uniform(32'd10, 32'd7, 1'b1, 32'd3, 32'd5);
    tick(); idle();
    tick();
    chk("single_lat2", 32'(sad_result_valid), 32'd0);
    tick();
    chk("single_valid", 32'(sad_result_valid), 32'd1);
    chk("single_sad", sad_result, 32'd48);
    tick();
    chk("single_best", best_sad, 32'd48);
    chk("single_bx", best_x, 32'd3);
    chk("single_by", best_y, 32'd5);
    chk("single_bv", 32'(best_valid), 32'd1);

    // Back-to-back 48, 20, 20: the tie keeps (4,5).
    drive_uniform(32'd10, 32'd7, 1'b1, 32'd3, 32'd5);
    tick();
    drive_single(32'd0, 32'd20, 1'b0, 32'd4, 32'd5);
    tick();
    drive_single(32'd20, 32'd0, 1'b0, 32'd6, 32'd6);
    tick(); idle();
    repeat (4) tick();
    chk("b2b_best", best_sad, 32'd20);
    chk("b2b_bx", best_x, 32'd4);
    chk("b2b_by", best_y, 32'd5);

    // Saturation.
    drive_uniform(32'hFFFF_FFFF, 32'd0, 1'b0, 32'd7, 32'd7);
    tick(); idle();
    tick(); tick();
    chk("sat_valid", 32'(sad_result_valid), 32'd1);
    chk("sat_sad", sad_result, 32'hFFFF_FFFF);
    tick();
    chk("sat_best_kept", best_sad, 32'd20);

    // Stall two cycles while the op sits in stage B.
    drive_single(32'd7, 32'd0, 1'b0, 32'd9, 32'd9);
    tick(); idle();
    tick();
    Stall = 1'b1;
    tick(); tick();
    chk("stall_no_valid", 32'(sad_result_valid), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    Stall = 1'b0;
    tick();
    chk("stall_valid", 32'(sad_result_valid), 32'd1);
    chk("stall_sad", sad_result, 32'd7);
    tick();
    chk("stall_best", best_sad, 32'd7);

    // Flush with three ops in flight, then a larger first op wins.
    drive_single(32'd1, 32'd0, 1'b0, 32'd1, 32'd1);
    tick();
    drive_single(32'd2, 32'd0, 1'b0, 32'd2, 32'd2);
    tick();
    drive_single(32'd3, 32'd0, 1'b0, 32'd3, 32'd3);
    Flush = 1'b1;
    tick();
    Flush = 1'b0; idle();
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_valid", 32'(sad_result_valid), 32'd0);
      tick();
    end
    chk("flush_best_kept", best_sad, 32'd7);
    drive_single(32'd100, 32'd0, 1'b1, 32'd11, 32'd12);
    tick(); idle();
    repeat (3) tick();
    chk("first_best", best_sad, 32'd100);
    chk("first_bx", best_x, 32'd11);
    chk("first_by", best_y, 32'd12);

    // Asynchronous reset while busy.
    drive_single(32'd5, 32'd0, 1'b0, 32'd1, 32'd2);
    tick(); tick(); idle();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    model_reset();
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_best", best_sad, 32'hFFFF_FFFF);
    chk("async_bv", 32'(best_valid), 32'd0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_valid", 32'(sad_result_valid), 32'd0);
      tick();
    end

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < NUM_PIX; i++) begin
        ReadData_EX6[i*PIX_W +: PIX_W]  = (mode == 0) ? $urandom : $urandom_range(0, 15);
        tReadData_EX6[i*PIX_W +: PIX_W] = (mode == 0) ? $urandom : $urandom_range(0, 15);
      end
      sad_valid_EX6 = ($urandom_range(0, 9) < 7);
      first_EX6     = ($urandom_range(0, 9) == 0);
      outx_EX6      = $urandom;
      outy_EX6      = $urandom;
      Stall         = ($urandom_range(0, 6) == 0);
      Flush         = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle();
    Stall = 1'b0;
    Flush = 1'b0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
